// File: rtl/simd_addsub_pipe.sv
// Pipelined SEW-partitioned SIMD add/sub with per-element carry/borrow/overflow flags.
// Define SIMD_ADDSUB_SAT_EN to build the saturating clamp in the final stage.
module simd_addsub_pipe #(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1,
  parameter int STAGES    = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SEW_WIDTH-1:0]              sew,
  input  logic                              op,
  input  logic                              sgn,
  input  logic                              sat,
  input  logic [MAX_WIDTH-1:0]              opA,
  input  logic [MAX_WIDTH-1:0]              opB,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [MAX_WIDTH-1:0]              result,
  output logic [MAX_WIDTH/MIN_WIDTH-1:0]    ovf
);
  localparam int ADDERS = MAX_WIDTH / MIN_WIDTH;
  localparam int C      = ADDERS / STAGES;

  logic                 v_q  [STAGES];
  logic [MAX_WIDTH-1:0] a_q  [STAGES];
  logic [MAX_WIDTH-1:0] b_q  [STAGES];
  logic [MAX_WIDTH-1:0] r_q  [STAGES];
  logic [ADDERS-1:0]    f_q  [STAGES];
  logic                 cy_q [STAGES];
  logic [SEW_WIDTH-1:0] sw_q [STAGES];
  logic                 op_q [STAGES];
  logic                 sg_q [STAGES];

  logic                 v_d  [STAGES];
  logic [MAX_WIDTH-1:0] a_d  [STAGES];
  logic [MAX_WIDTH-1:0] b_d  [STAGES];
  logic [MAX_WIDTH-1:0] r_d  [STAGES];
  logic [ADDERS-1:0]    f_d  [STAGES];
  logic                 cy_d [STAGES];
  logic [SEW_WIDTH-1:0] sw_d [STAGES];
  logic                 op_d [STAGES];
  logic                 sg_d [STAGES];

  logic [MAX_WIDTH-1:0] a_s, b_s, r_s;
  logic [ADDERS-1:0]    f_s;
  logic [SEW_WIDTH-1:0] sw_s;
  logic                 op_s, sg_s, c;
  logic [MIN_WIDTH-1:0] ach, bch, lo;
  logic [1:0]           hi;
  int                   prev;
  logic                 advance;

`ifdef SIMD_ADDSUB_SAT_EN
  logic st_q [STAGES];
  logic st_d [STAGES];
  logic st_s, cl, neg, top;
`else
  logic sat_unused;
  assign sat_unused = sat;
`endif

  // Chunk j starts an element when any selected width has a boundary there.
  function automatic logic is_base(input logic [SEW_WIDTH-1:0] sw, input int j);
    logic b;
    b = (j == 0);
    for (int k = 0; k < SEW_WIDTH; k++)
      if (sw[k] && (j % (ADDERS >> k)) == 0) b = 1'b1;
    return b;
  endfunction

  function automatic logic is_top(input logic [SEW_WIDTH-1:0] sw, input int j);
    return (j == ADDERS - 1) || is_base(sw, j + 1);
  endfunction

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign result    = r_q[STAGES-1];
  assign ovf       = f_q[STAGES-1];

  always_comb begin
    v_d  = '{default: '0};
    a_d  = '{default: '0};
    b_d  = '{default: '0};
    r_d  = '{default: '0};
    f_d  = '{default: '0};
    cy_d = '{default: '0};
    sw_d = '{default: '0};
    op_d = '{default: '0};
    sg_d = '{default: '0};
    a_s = '0; b_s = '0; r_s = '0; f_s = '0; sw_s = '0;
    op_s = 1'b0; sg_s = 1'b0; c = 1'b0;
    ach = '0; bch = '0; lo = '0; hi = '0; prev = 0;
`ifdef SIMD_ADDSUB_SAT_EN
    st_d = '{default: '0};
    st_s = 1'b0; cl = 1'b0; neg = 1'b0; top = 1'b0;
`endif
    for (int s = 0; s < STAGES; s++) begin
      prev = (s > 0) ? s - 1 : 0;
      a_s  = (s > 0) ? a_q[prev]  : opA;
      b_s  = (s > 0) ? b_q[prev]  : opB;
      r_s  = (s > 0) ? r_q[prev]  : '0;
      f_s  = (s > 0) ? f_q[prev]  : '0;
      sw_s = (s > 0) ? sw_q[prev] : sew;
      op_s = (s > 0) ? op_q[prev] : op;
      sg_s = (s > 0) ? sg_q[prev] : sgn;
      c    = (s > 0) ? cy_q[prev] : 1'b0;
`ifdef SIMD_ADDSUB_SAT_EN
      st_s = (s > 0) ? st_q[prev] : sat;
`endif
      // MSB is added separately so the carry into it is visible for signed overflow.
      for (int j = s * C; j < (s + 1) * C; j++) begin
        ach = a_s[j*MIN_WIDTH +: MIN_WIDTH];
        bch = b_s[j*MIN_WIDTH +: MIN_WIDTH] ^ {MIN_WIDTH{op_s}};
        if (is_base(sw_s, j)) c = op_s;
        lo = {1'b0, ach[MIN_WIDTH-2:0]} + {1'b0, bch[MIN_WIDTH-2:0]} + MIN_WIDTH'(c);
        hi = {1'b0, ach[MIN_WIDTH-1]} + {1'b0, bch[MIN_WIDTH-1]} + {1'b0, lo[MIN_WIDTH-1]};
        r_s[j*MIN_WIDTH +: MIN_WIDTH] = {hi[0], lo[MIN_WIDTH-2:0]};
        f_s[j] = is_top(sw_s, j) & (sg_s ? (lo[MIN_WIDTH-1] ^ hi[1]) : (op_s ^ hi[1]));
        c = hi[1];
      end
`ifdef SIMD_ADDSUB_SAT_EN
      // Walk downward so every chunk inherits the flag and opA sign of its element top.
      if (s == STAGES - 1 && st_s) begin
        for (int j = ADDERS - 1; j >= 0; j--) begin
          top = is_top(sw_s, j);
          if (top) begin
            cl  = f_s[j];
            neg = a_s[j*MIN_WIDTH + MIN_WIDTH - 1];
          end
          if (cl)
            r_s[j*MIN_WIDTH +: MIN_WIDTH] = !sg_s ? {MIN_WIDTH{~op_s}} :
                top ? {neg, {(MIN_WIDTH-1){~neg}}} : {MIN_WIDTH{~neg}};
        end
      end
      st_d[s] = st_s;
`endif
      v_d[s]  = (s > 0) ? v_q[prev] : in_valid;
      a_d[s]  = a_s;
      b_d[s]  = b_s;
      r_d[s]  = r_s;
      f_d[s]  = f_s;
      cy_d[s] = c;
      sw_d[s] = sw_s;
      op_d[s] = op_s;
      sg_d[s] = sg_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '{default: '0};
      a_q  <= '{default: '0};
      b_q  <= '{default: '0};
      r_q  <= '{default: '0};
      f_q  <= '{default: '0};
      cy_q <= '{default: '0};
      sw_q <= '{default: '0};
      op_q <= '{default: '0};
      sg_q <= '{default: '0};
`ifdef SIMD_ADDSUB_SAT_EN
      st_q <= '{default: '0};
`endif
    end else if (advance) begin
      v_q  <= v_d;
      a_q  <= a_d;
      b_q  <= b_d;
      r_q  <= r_d;
      f_q  <= f_d;
      cy_q <= cy_d;
      sw_q <= sw_d;
      op_q <= op_d;
      sg_q <= sg_d;
`ifdef SIMD_ADDSUB_SAT_EN
      st_q <= st_d;
`endif
    end
  end

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// Scoreboard bench for simd_addsub_pipe (64-bit datapath, byte chunks, two stages).
module tb_simd_addsub_pipe;
`ifdef SIMD_ADDSUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] r;
    logic [7:0]  f;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  sew = '0;
  logic        op = 1'b0, sgn = 1'b0, sat = 1'b0;
  logic [63:0] opA = '0, opB = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic [7:0]  ovf;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0, n_pass = 0, n_out = 0, cyc = 0, acc_cyc = 0;

  simd_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sew(sew), .op(op), .sgn(sgn), .sat(sat), .opA(opA), .opB(opB),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: element-wise arithmetic on whole element values.
  function automatic exp_t model(input logic [3:0] sw, input logic o, input logic sg,
                                 input logic st, input logic [63:0] a, input logic [63:0] b);
    exp_t x;
    int w;
    logic [64:0] ea, eb, full;
    logic [63:0] m, res;
    logic sa, sb_, sr, fl;
    w = 64;
    for (int k = 0; k < 4; k++) if (sw[k]) w = 64 >> k;
    x = '0;
    for (int e = 0; e < 64 / w; e++) begin
      m    = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      ea   = {1'b0, (a >> (e * w)) & m};
      eb   = {1'b0, (b >> (e * w)) & m};
      full = o ? (ea - eb) : (ea + eb);
      res  = full[63:0] & m;
      sa = ea[w-1]; sb_ = eb[w-1]; sr = res[w-1];
      if (sg) fl = o ? (sa != sb_ && sr != sa) : (sa == sb_ && sr != sa);
      else    fl = o ? (ea < eb) : full[w];
      if (st && SAT_EN && fl)
        res = !sg ? (o ? 64'd0 : m) : (sa ? (64'd1 << (w - 1)) : (m >> 1));
      x.r = x.r | (res << (e * w));
      x.f[(e * w + w) / 8 - 1] = fl;
    end
    return x;
  endfunction

  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output result=%h ovf=%b", result, ovf);
      end else begin
        mon_e = sb.pop_front();
        n_chk++;
        if (result !== mon_e.r) $display("FAIL result got=%h exp=%h", result, mon_e.r);
        else n_pass++;
        n_chk++;
        if (ovf !== mon_e.f) $display("FAIL ovf got=%b exp=%b", ovf, mon_e.f);
        else n_pass++;
      end
    end
  end

  task automatic send(input logic [3:0] sw, input logic o, input logic sg, input logic st,
                      input logic [63:0] a, input logic [63:0] b);
    int budget = 0;
    sew = sw; op = o; sgn = sg; sat = st; opA = a; opB = b; in_valid = 1'b1;
    #1;
    while (!in_ready && budget < 20) begin
      @(posedge clk); @(negedge clk); #1;
      budget++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout in_ready got=%b exp=1", in_ready);
    end else begin
      sb.push_back(model(sw, o, sg, st, a, b));
      acc_cyc = cyc;
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) $display("FAIL drain pending got=%0d exp=0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_chk++; if (result !== 64'd0) $display("FAIL rst_result got=%h exp=0", result); else n_pass++;
    n_chk++; if (ovf !== 8'd0) $display("FAIL rst_ovf got=%b exp=0", ovf); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_byte_add();
    out_ready = 1'b1;
    send(4'b1000, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001);
    drain();
  endtask

  task automatic test_sub64();
    int lat;
    out_ready = 1'b1;
    send(4'b0001, 1'b1, 1'b0, 1'b0, 64'd0, 64'd1);
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    n_chk++;
    if (lat != 2) $display("FAIL sub64_latency got=%0d exp=2", lat); else n_pass++;
    drain();
  endtask

  task automatic test_signed16();
    out_ready = 1'b1;
    send(4'b0100, 1'b0, 1'b1, 1'b0, 64'h7FFF, 64'h0001);
    send(4'b0100, 1'b0, 1'b1, 1'b1, 64'h7FFF, 64'h0001);
    send(4'b0100, 1'b0, 1'b1, 1'b1, 64'h8000, 64'h8000);
    send(4'b0100, 1'b1, 1'b0, 1'b1, 64'h0000, 64'h0001);
    send(4'b0100, 1'b0, 1'b0, 1'b1, 64'hFFFF_0001, 64'h0001_0001);
    drain();
  endtask

  task automatic test_backpressure();
    logic [63:0] a_t [4];
    int idx = 0;
    int base;
    for (int i = 0; i < 4; i++) a_t[i] = 64'h1111_1111_1111_1111 * (i + 1);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      sew = 4'b0010; op = 1'b0; sgn = 1'b0; sat = 1'b0;
      opA = a_t[idx]; opB = 64'h0101_0101_0101_0101; in_valid = 1'b1;
      #1;
      if (in_ready) begin
        sb.push_back(model(sew, op, sgn, sat, opA, opB));
        idx++;
      end
      if (c >= 3) begin
        n_chk++;
        if (result !== sb[0].r) $display("FAIL bp_head_stable got=%h exp=%h", result, sb[0].r);
        else n_pass++;
      end
      @(posedge clk); @(negedge clk);
    end
    n_chk++; if (idx != 2) $display("FAIL bp_accepted got=%0d exp=2", idx); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else n_pass++;
    base = n_out;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 4);
      opA = a_t[(idx < 4) ? idx : 3];
      #1;
      if (in_valid && in_ready) begin
        sb.push_back(model(sew, op, sgn, sat, opA, opB));
        idx++;
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++; if (n_out - base != 4) $display("FAIL bp_drain_count got=%0d exp=4", n_out - base); else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b0;
    send(4'b1000, 1'b0, 1'b0, 1'b0, 64'h0102_0304_0506_0708, 64'h1111_1111_1111_1111);
    send(4'b0001, 1'b1, 1'b1, 1'b0, 64'h7777_0000_0000_0000, 64'h0000_0000_0000_0005);
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (result !== 64'd0) $display("FAIL rstmid_result got=%h exp=0", result); else n_pass++;
    n_chk++; if (ovf !== 8'd0) $display("FAIL rstmid_ovf got=%b exp=0", ovf); else n_pass++;
    sb.delete();
    @(negedge clk); #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b0) $display("FAIL rstmid_stale got=%b exp=0", out_valid); else n_pass++;
    end
    send(4'b0010, 1'b0, 1'b0, 1'b0, 64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0001);
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    n_chk++; if (lat != 2) $display("FAIL rstmid_latency got=%0d exp=2", lat); else n_pass++;
    drain();
  endtask

  task automatic test_mixed_sew();
    int c0, c1, c2;
    out_ready = 1'b1;
    send(4'b1000, 1'b0, 1'b0, 1'b0, 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080);
    c0 = acc_cyc;
    send(4'b0010, 1'b0, 1'b0, 1'b0, 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080);
    c1 = acc_cyc;
    send(4'b0001, 1'b0, 1'b0, 1'b0, 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080);
    c2 = acc_cyc;
    n_chk++; if (c1 - c0 != 1) $display("FAIL b2b_gap1 got=%0d exp=1", c1 - c0); else n_pass++;
    n_chk++; if (c2 - c1 != 1) $display("FAIL b2b_gap2 got=%0d exp=1", c2 - c1); else n_pass++;
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      sew = 4'($urandom); op = 1'($urandom); sgn = 1'($urandom); sat = 1'($urandom);
      opA = {$urandom, $urandom}; opB = {$urandom, $urandom};
      #1;
      if (in_valid && in_ready) sb.push_back(model(sew, op, sgn, sat, opA, opB));
      @(posedge clk); @(negedge clk);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_byte_add();
    test_sub64();
    test_signed16();
    test_backpressure();
    test_reset_mid();
    test_mixed_sew();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/simd_addsub_pipe.md
# simd_addsub_pipe

Pipelined, SEW-partitioned SIMD add/subtract unit for the execution SIMD cluster, next generation of the combinational lane adder. The MAX_WIDTH datapath is split into MIN_WIDTH chunks, and element boundaries are selected per transaction by `sew`. The carry chain is cut into STAGES register stages with a valid/ready handshake on both sides. The unit adds per-element overflow/carry flags and optional saturation.

## Interface
- MIN_WIDTH, 8: chunk width in bits; also the narrowest element.
- MAX_WIDTH, 64: datapath width; must be MIN_WIDTH·2^n.
- SEW_WIDTH, $clog2(MAX_WIDTH/MIN_WIDTH)+1: width of the `sew` select.
- STAGES, 2: pipeline depth; must divide ADDERS = MAX_WIDTH/MIN_WIDTH, range 1..ADDERS.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  unit accepts the transaction this cycle.
- sew  in  SEW_WIDTH  element width select; bit k means element width MAX_WIDTH>>k.
- op  in  1  0 = A+B, 1 = A−B.
- sgn  in  1  signed interpretation, used for flags and saturation.
- sat  in  1  saturate; ignored unless SIMD_ADDSUB_SAT_EN is defined.
- opA, opB  in  MAX_WIDTH  packed operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  MAX_WIDTH  packed result.
- ovf  out  ADDERS  per-chunk flag; meaningful only at each element's top chunk, 0 elsewhere.

## Operation
- Element width select:
  - Chunk boundary j (between chunk j−1 and j) is an element boundary if any sew[k] is set with j a multiple of ADDERS>>k.
  - If several sew bits are set, the narrowest width wins.
  - sew = 0 behaves as MAX_WIDTH.
- Subtraction: opB is inverted and carry-in = 1 at every element base chunk. Addition uses carry-in = 0.
- Inside an element, carry propagates chunk to chunk. No carry crosses an element boundary.
- Pipeline structure:
  - Stage s (0..STAGES−1) computes chunks [s·C, (s+1)·C), where C = ADDERS/STAGES.
  - The carry out of chunk (s+1)·C−1 is registered into stage s+1.
  - Lower partial results, remaining operands, sew, op, sgn and sat travel with the transaction.
- Flag at an element's top chunk:
  - Unsigned add: carry-out.
  - Unsigned sub: borrow (inverted carry-out).
  - Signed: two's-complement overflow (carry into MSB XOR carry out of MSB).
- Results wrap modulo 2^element_width.
- Flow control:
  - Global stall: advance = !out_valid | out_ready.
  - in_ready = advance.
  - Bubbles are not collapsed; each stage's valid bit shifts on advance.
- Transactions emerge in acceptance order. No data is dropped or duplicated.
- Reset (any time, including mid-operation): all stage valids, result, ovf and pipeline data registers go to 0.
  - out_valid = 0 and in_ready = 1 from the first cycle after the reset edge.
  - In-flight transactions are discarded.

## Timing
- Latency is exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid, with no stall.
- Throughput is 1 transaction per cycle when out_ready = 1.
- result and ovf are registered outputs, stable while out_valid & !out_ready.
- Simultaneous accept and drain in one cycle is legal and keeps full throughput.
- in_ready depends combinationally on out_ready only. No combinational path from opA/opB to any output.
- STAGES = 1 gives a single-register unit with latency 1.

## Configuration
- SIMD_ADDSUB_SAT_EN defined:
  - When sat = 1, each element whose flag is set is clamped:
    - unsigned add → all-ones
    - unsigned sub → 0
    - signed → 0x7F..F or 0x80..0, chosen by sign of opA.
  - Clamping is applied in the final stage over all chunks of the element.
  - Latency is unchanged.
- SIMD_ADDSUB_SAT_EN undefined:
  - The `sat` port exists but is ignored; results always wrap.
  - No clamp logic is generated.

## Test plan
- Byte add, unsigned:
  - Stimulus: sew=4'b1000, op=0, sgn=0, opA=0x00000000000000FF, opB=0x0000000000000001.
  - Expect result=0x0000000000000000, ovf[0]=1, all other ovf=0, byte 1 untouched.
- 64-bit sub:
  - Stimulus: sew=4'b0001, op=1, opA=0, opB=1.
  - Expect result=0xFFFFFFFFFFFFFFFF, ovf[7]=1.
  - out_valid rises exactly 2 cycles after accept (STAGES=2).
- Signed 16-bit overflow:
  - Stimulus: sew=4'b0100, sgn=1, op=0, sat=0, lane0 0x7FFF+0x0001.
  - Expect lane0 result=0x8000, ovf[1]=1.
  - With SIMD_ADDSUB_SAT_EN and sat=1: expect 0x7FFF, ovf[1]=1.
  - Also with SAT_EN, unsigned sub 0x0000−0x0001 with sat=1 → 0x0000.
- Backpressure:
  - Stimulus: out_ready=0, in_valid=1 for 4 distinct transactions.
  - Expect exactly 2 accepted, then in_ready=0 while the pipeline is full. The head result holds stable.
  - Then out_ready=1: all 4 emerge in order, one per cycle, none lost.
- Reset mid-operation:
  - Stimulus: 2 transactions in flight, rst_n pulsed low asynchronously between edges.
  - Expect out_valid=0, result=0, ovf=0 immediately.
  - After release, no stale result appears and the next transaction completes with latency 2.
- Mixed sew back-to-back:
  - Stimulus: sew 8-bit, 32-bit, 64-bit issued on consecutive cycles with opA=opB=0x80808080_80808080, op=0.
  - Expect results 0x00000000_00000000, 0x01010100_01010100, 0x01010101_01010100 in order.
